// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester asynchronous SRAM arbiter.
//   state_t    : access sequencer states
//   ADDR_W_DEF : default SRAM word-address width
//   DATA_W_DEF : default SRAM data width
//   OP_READ / OP_WRITE : latched operation type
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin grant selection (combinational).
//   req         in  2  pending requests
//   last_grant  in  1  requester served most recently
//   grant_valid out 1  at least one request pending
//   grant_id    out 1  selected requester
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // On a tie the requester that was not served last wins; otherwise the
    // only active requester wins.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between two requesters and sequences the
// multi-cycle read/write timing. All outputs are registered.
//   Clk, Reset      clock, asynchronous active-high reset
//   req/we/be/addr/wdata  per-requester request bundles (index 0 in the low slice)
//   ack             one-cycle completion pulse per requester
//   rdata           read data, valid from the ack cycle until the next read completes
//   SRAM_ADDR, Data_to_SRAM, Data_from_SRAM, Data_OE   SRAM address/data pads
//   Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE             active-low SRAM controls
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [3:0]            be,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    output logic [DATA_W-1:0]     Data_to_SRAM,
    input  logic [DATA_W-1:0]     Data_from_SRAM,
    output logic                  Data_OE,
    output logic                  Mem_CE,
    output logic                  Mem_UB,
    output logic                  Mem_LB,
    output logic                  Mem_OE,
    output logic                  Mem_WE
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              op_q, op_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              data_oe_q, data_oe_d;
    logic              ce_q, ce_d;
    logic              ub_q, ub_d;
    logic              lb_q, lb_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;

    logic              grant_valid;
    logic              grant_id;
    logic [1:0]        be_sel;

    rr_arbiter2 u_rr (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign be_sel = grant_id ? be[3:2] : be[1:0];

    // State and output registers; reset drops any access in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= OP_READ;
            ack_q        <= 2'b00;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_oe_q    <= 1'b0;
            ce_q         <= 1'b1;
            ub_q         <= 1'b1;
            lb_q         <= 1'b1;
            oe_q         <= 1'b1;
            we_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_oe_q    <= data_oe_d;
            ce_q         <= ce_d;
            ub_q         <= ub_d;
            lb_q         <= lb_d;
            oe_q         <= oe_d;
            we_q         <= we_d;
        end
    end

    // Next state plus the value each output will carry in that next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        ack_d        = 2'b00;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_oe_d    = data_oe_q;
        ce_d         = ce_q;
        ub_d         = ub_q;
        lb_d         = lb_q;
        oe_d         = oe_q;
        we_d         = we_q;

        case (state_q)
            IDLE: begin
                ce_d      = 1'b1;
                ub_d      = 1'b1;
                lb_d      = 1'b1;
                oe_d      = 1'b1;
                we_d      = 1'b1;
                data_oe_d = 1'b0;
                if (grant_valid) begin
                    grant_d   = grant_id;
                    op_d      = grant_id ? we[1] : we[0];
                    addr_d    = grant_id ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
                    wdata_d   = grant_id ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                    cnt_d     = '0;
                    state_d   = ACCESS;
                    ce_d      = 1'b0;
                    ub_d      = ~be_sel[1];
                    lb_d      = ~be_sel[0];
                    oe_d      = (op_d == OP_WRITE);
                    we_d      = (op_d == OP_READ);
                    data_oe_d = (op_d == OP_WRITE);
                end
            end

            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (op_q == OP_READ) begin
                        rdata_d = Data_from_SRAM;
                    end
                    // Address, CE, byte strobes and Data_OE stay put through DONE
                    // so write data is held past the WE rising edge.
                    oe_d           = 1'b1;
                    we_d           = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end
            end

            DONE: begin
                last_grant_d = grant_q;
                ce_d         = 1'b1;
                ub_d         = 1'b1;
                lb_d         = 1'b1;
                data_oe_d    = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign SRAM_ADDR    = addr_q;
    assign Data_to_SRAM = wdata_q;
    assign Data_OE      = data_oe_q;
    assign Mem_CE       = ce_q;
    assign Mem_UB       = ub_q;
    assign Mem_LB       = lb_q;
    assign Mem_OE       = oe_q;
    assign Mem_WE       = we_q;

endmodule
